mux_rr_nx1: RTL and testbench

- Parametrised N-to-1 multiplexer with a registered output stage and a valid/ready handshake on every input channel and on the output.
- Two modes: fixed select, as in the 4x1 combinational mux, or round-robin arbitration across all channels with valid data.
- One beat per cycle at full throughput.
- Sits between multiple producer streams and a single consumer in the datapath.

---
 rtl/mux_rr_nx1.sv | 83 ++++++++
 tb/tb_mux_rr_nx1.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nx1.sv
// N-to-1 stream multiplexer with a registered output beat; the channel is chosen either by a
// fixed select or by a round-robin scan that starts at the channel after the last one granted.
module mux_rr_nx1 #(
  parameter int WIDTH = 32,
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  input  logic                      out_ready
);

  logic             load_en;
  logic             grant_valid;
  logic [SEL_W-1:0] g;
  logic [WIDTH-1:0] g_data;
  logic [SEL_W-1:0] ptr;

  assign load_en = !out_valid || out_ready;

  // Grant selection: an out-of-range select simply never matches a channel.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    g           = '0;
    g_data      = '0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (select == SEL_W'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          g           = SEL_W'(i);
          g_data      = in_data[i*WIDTH +: WIDTH];
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        idx = int'(ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!grant_valid && in_valid[idx]) begin
          grant_valid = 1'b1;
          g           = SEL_W'(idx);
          g_data      = in_data[idx*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = rst_n && load_en && grant_valid && (g == SEL_W'(i));
    end
  end

  // Output register stage; ptr wraps explicitly so non-power-of-2 channel counts work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_ch    <= g;
        if (mode) ptr <= (g == SEL_W'(CHANNELS-1)) ? '0 : g + SEL_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Self-checking bench for mux_rr_nx1: directed scenarios on a 4x32 and a 3x8 instance plus a
// randomized scoreboard run against a behavioural arbitration model.
module tb_mux_rr_nx1;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int W3 = 8;
  localparam int N3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic [N-1:0]   in_valid = '0, in_ready;
  logic [N*W-1:0] in_data = '0;
  logic           mode = 1'b0, out_ready = 1'b1, out_valid;
  logic [1:0]     select = '0, out_ch;
  logic [W-1:0]   out_data;

  logic [N3-1:0]    v3 = '0, r3;
  logic [N3*W3-1:0] d3 = '0;
  logic             mode3 = 1'b0, ordy3 = 1'b1, ov3;
  logic [1:0]       sel3 = '0, oc3;
  logic [W3-1:0]    od3;

  int checks = 0;
  int failures = 0;

  mux_rr_nx1 #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mode(mode), .select(select), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready));

  mux_rr_nx1 #(.WIDTH(W3), .CHANNELS(N3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(r3),
    .mode(mode3), .select(sel3), .out_valid(ov3), .out_data(od3), .out_ch(oc3),
    .out_ready(ordy3));

  // Round-robin winner: first valid channel counting upward from p, modulo n.
  function automatic int rr_pick(int p, logic [N-1:0] v, int n);
    for (int k = 0; k < n; k++) if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0; in_data = '0; mode = 1'b0; select = '0; out_ready = 1'b1;
    v3 = '0; d3 = '0; mode3 = 1'b0; sel3 = '0; ordy3 = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 4'($urandom); in_data = {$urandom, $urandom, $urandom, $urandom};
      mode = 1'($urandom); select = 2'($urandom); out_ready = 1'($urandom);
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++; if (out_ch !== 2'd0) begin failures++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
      checks++; if (in_ready !== 4'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
      tick();
    end
    in_valid = '0; out_ready = 1'b1;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%0b exp=0", out_valid); end
    end
  endtask

  task automatic test_fixed_sweep();
    do_reset();
    mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h11111111 * i;
    for (int s = 0; s < N; s++) begin
      select = 2'(s);
      #1;
      checks++; if (in_ready !== 4'(1 << s)) begin failures++; $display("FAIL sweep_in_ready sel=%0d got=%b exp=%b", s, in_ready, 4'(1 << s)); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h11111111 * s || out_ch !== 2'(s)) begin
        failures++; $display("FAIL sweep_out sel=%0d got=%0b/%h/%0d exp=1/%h/%0d", s, out_valid, out_data, out_ch, 32'h11111111 * s, s);
      end
    end
  endtask

  task automatic test_fixed_invalid();
    do_reset();
    mode = 1'b0; in_valid = 4'b1011; out_ready = 1'b1; select = 2'd1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h11111111 * i;
    tick();
    select = 2'd2;
    #1;
    checks++; if (in_ready !== 4'b0) begin failures++; $display("FAIL invalid_in_ready got=%b exp=0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h11111111 || out_ch !== 2'd1) begin
      failures++; $display("FAIL invalid_drain got=%0b/%h/%0d exp=0/11111111/1", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_rr_fairness();
    logic [W-1:0] dat [N];
    int exp_tail [3] = '{3, 1, 3};
    do_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin dat[i] = $urandom; in_data[i*W +: W] = dat[i]; end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'(c % N) || out_data !== dat[c % N]) begin
        failures++; $display("FAIL rr_seq c=%0d got=%0b/%0d/%h exp=1/%0d/%h", c, out_valid, out_ch, out_data, c % N, dat[c % N]);
      end
    end
    in_valid = 4'b0010;
    tick();
    checks++; if (out_ch !== 2'd1) begin failures++; $display("FAIL rr_ch1 got=%0d exp=1", out_ch); end
    in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (out_ch !== 2'(exp_tail[c]) || out_data !== dat[exp_tail[c]]) begin
        failures++; $display("FAIL rr_sparse c=%0d got=%0d/%h exp=%0d/%h", c, out_ch, out_data, exp_tail[c], dat[exp_tail[c]]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] dat [N];
    do_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin dat[i] = $urandom; in_data[i*W +: W] = dat[i]; end
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (in_ready !== 4'b0) begin failures++; $display("FAIL stall_in_ready c=%0d got=%b exp=0000", c, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== dat[0]) begin
        failures++; $display("FAIL stall_hold c=%0d got=%0b/%0d/%h exp=1/0/%h", c, out_valid, out_ch, out_data, dat[0]);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL stall_release_ready got=%b exp=0010", in_ready); end
    tick();
    checks++; if (out_ch !== 2'd1 || out_data !== dat[1]) begin
      failures++; $display("FAIL stall_resume got=%0d/%h exp=1/%h", out_ch, out_data, dat[1]);
    end
  endtask

  task automatic test_random_scoreboard();
    logic [N-1:0] pend = '0;
    logic [W-1:0] pdat [N];
    logic [W+1:0] q [$];
    logic [W+1:0] exp_beat;
    logic         mvalid = 1'b0, le;
    logic [W-1:0] mdata = '0;
    int mch = 0, mp = 0, g, beats = 0;
    logic [N-1:0] exp_rdy;
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < N; i++) pdat[i] = '0;
    for (int cyc = 0; cyc < 3000 && beats < 100; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin pend[i] = 1'b1; pdat[i] = $urandom; end
        in_data[i*W +: W] = pdat[i];
      end
      in_valid = pend;
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      select = 2'($urandom);
      #1;
      le = !mvalid || out_ready;
      g = mode ? rr_pick(mp, in_valid, N) : (in_valid[select] ? int'(select) : -1);
      exp_rdy = (le && g >= 0) ? 4'(1 << g) : 4'b0;
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
      checks++; if (out_valid !== mvalid) begin failures++; $display("FAIL rand_out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, mvalid); end
      if (mvalid) begin
        checks++; if (out_data !== mdata || out_ch !== 2'(mch)) begin
          failures++; $display("FAIL rand_out cyc=%0d got=%h/%0d exp=%h/%0d", cyc, out_data, out_ch, mdata, mch);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rand_sb_extra cyc=%0d got=%h/%0d exp=none", cyc, out_data, out_ch);
        end else begin
          exp_beat = q.pop_front();
          if ({out_ch, out_data} !== exp_beat) begin
            failures++; $display("FAIL rand_sb cyc=%0d got=%0d/%h exp=%0d/%h", cyc, out_ch, out_data, exp_beat[W+1:W], exp_beat[W-1:0]);
          end
        end
        beats++;
      end
      if (le) begin
        if (g >= 0) begin
          q.push_back({2'(g), pdat[g]});
          pend[g] = 1'b0;
          mvalid = 1'b1; mdata = pdat[g]; mch = g;
          if (mode) mp = (g + 1) % N;
        end else begin
          mvalid = 1'b0;
        end
      end
      tick();
    end
    checks++; if (beats < 100) begin failures++; $display("FAIL rand_timeout got=%0d exp=100 beats", beats); end
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 1'b0; select = 2'd3; in_valid = 4'hF; out_ready = 1'b0;
    in_data[3*W +: W] = 32'hDEADBEEF;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL async_load got=%0b/%h exp=1/deadbeef", out_valid, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== 2'd0) begin
      failures++; $display("FAIL async_reset got=%0b/%h/%0d exp=0/0/0", out_valid, out_data, out_ch);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_non_pow2();
    logic [W3-1:0] dat [N3];
    int exp_seq [4] = '{0, 1, 2, 0};
    do_reset();
    mode3 = 1'b1; v3 = 3'b111; ordy3 = 1'b1;
    for (int i = 0; i < N3; i++) begin dat[i] = 8'($urandom); d3[i*W3 +: W3] = dat[i]; end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (ov3 !== 1'b1 || oc3 !== 2'(exp_seq[c]) || od3 !== dat[exp_seq[c]]) begin
        failures++; $display("FAIL np2_rr c=%0d got=%0b/%0d/%h exp=1/%0d/%h", c, ov3, oc3, od3, exp_seq[c], dat[exp_seq[c]]);
      end
    end
    mode3 = 1'b0; sel3 = 2'd3;
    #1;
    checks++; if (r3 !== 3'b0) begin failures++; $display("FAIL np2_sel3_ready got=%b exp=000", r3); end
    tick();
    checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL np2_sel3_valid got=%0b exp=0", ov3); end
  endtask

  initial begin
    test_reset();
    test_fixed_sweep();
    test_fixed_invalid();
    test_rr_fairness();
    test_backpressure();
    test_random_scoreboard();
    test_async_reset();
    test_non_pow2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
